// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Each requester gets its own response register that holds until it is consumed.
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             a_req_valid_i,
    output logic             a_req_ready_o,
    input  logic [WIDTH-1:0] a_src1_i,
    input  logic [WIDTH-1:0] a_src2_i,
    input  logic [3:0]       a_ctrl_i,
    output logic             a_resp_valid_o,
    input  logic             a_resp_ready_i,
    output logic [WIDTH-1:0] a_result_o,
    output logic             a_zero_o,
    output logic             a_ovf_o,

    input  logic             b_req_valid_i,
    output logic             b_req_ready_o,
    input  logic [WIDTH-1:0] b_src1_i,
    input  logic [WIDTH-1:0] b_src2_i,
    input  logic [3:0]       b_ctrl_i,
    output logic             b_resp_valid_o,
    input  logic             b_resp_ready_i,
    output logic [WIDTH-1:0] b_result_o,
    output logic             b_zero_o,
    output logic             b_ovf_o,

    output logic [WIDTH-1:0] alu_src1_o,
    output logic [WIDTH-1:0] alu_src2_o,
    output logic             alu_invA_o,
    output logic             alu_invB_o,
    output logic [1:0]       alu_op_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_zero_i,
    input  logic             alu_ovf_i
);

    localparam logic IDLE   = 1'b0;
    localparam logic EXEC   = 1'b1;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    logic             state_q, state_d;
    logic             last_q;
    logic             port_q;
    logic [WIDTH-1:0] src1_q, src2_q;
    logic [3:0]       ctrl_q;

    logic             a_resp_valid_q, b_resp_valid_q;
    logic [WIDTH-1:0] a_result_q, b_result_q;
    logic             a_zero_q, b_zero_q, a_ovf_q, b_ovf_q;

    logic elig_a, elig_b, grant_a, grant_b, accept;

    // A port with a response still held cannot issue, even during its handshake cycle.
    always_comb begin
        elig_a  = a_req_valid_i & ~a_resp_valid_q;
        elig_b  = b_req_valid_i & ~b_resp_valid_q;
        grant_a = (state_q == IDLE) & elig_a & (~elig_b | (last_q == PORT_B));
        grant_b = (state_q == IDLE) & elig_b & (~elig_a | (last_q == PORT_A));
        accept  = grant_a | grant_b;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) begin
            if (accept) begin
                state_d = EXEC;
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            last_q  <= PORT_B;
            port_q  <= PORT_A;
            src1_q  <= '0;
            src2_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_q <= grant_b;
                port_q <= grant_b;
                src1_q <= grant_b ? b_src1_i : a_src1_i;
                src2_q <= grant_b ? b_src2_i : a_src2_i;
                ctrl_q <= grant_b ? b_ctrl_i : a_ctrl_i;
            end
        end
    end

    // The granted port's valid is low throughout EXEC, so capture and
    // handshake-clear never target the same port on the same edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            a_resp_valid_q <= 1'b0;
            a_result_q     <= '0;
            a_zero_q       <= 1'b0;
            a_ovf_q        <= 1'b0;
        end else if (state_q == EXEC && port_q == PORT_A) begin
            a_resp_valid_q <= 1'b1;
            a_result_q     <= alu_result_i;
            a_zero_q       <= alu_zero_i;
            a_ovf_q        <= alu_ovf_i;
        end else if (a_resp_valid_q && a_resp_ready_i) begin
            a_resp_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            b_resp_valid_q <= 1'b0;
            b_result_q     <= '0;
            b_zero_q       <= 1'b0;
            b_ovf_q        <= 1'b0;
        end else if (state_q == EXEC && port_q == PORT_B) begin
            b_resp_valid_q <= 1'b1;
            b_result_q     <= alu_result_i;
            b_zero_q       <= alu_zero_i;
            b_ovf_q        <= alu_ovf_i;
        end else if (b_resp_valid_q && b_resp_ready_i) begin
            b_resp_valid_q <= 1'b0;
        end
    end

    assign a_req_ready_o  = grant_a;
    assign b_req_ready_o  = grant_b;

    assign a_resp_valid_o = a_resp_valid_q;
    assign a_result_o     = a_result_q;
    assign a_zero_o       = a_zero_q;
    assign a_ovf_o        = a_ovf_q;

    assign b_resp_valid_o = b_resp_valid_q;
    assign b_result_o     = b_result_q;
    assign b_zero_o       = b_zero_q;
    assign b_ovf_o        = b_ovf_q;

    assign alu_src1_o     = src1_q;
    assign alu_src2_o     = src2_q;
    assign alu_invA_o     = ctrl_q[3];
    assign alu_invB_o     = ctrl_q[2];
    assign alu_op_o       = ctrl_q[1:0];

endmodule
